// File: rtl/rv_pkg.sv
// Shared RV32I memory-stage definitions: load/store width codes, LSU FSM states,
// and the datapath geometry constants.
package rv_pkg;

  localparam int unsigned XLEN          = 32;
  localparam int unsigned DMEM_ADDR_BIT = 12;

  typedef enum logic [2:0] {
    F3_B  = 3'b000,
    F3_H  = 3'b001,
    F3_W  = 3'b010,
    F3_BU = 3'b100,
    F3_HU = 3'b101
  } ls_funct3_e;

  typedef enum logic {
    IDLE       = 1'b0,
    FIRST_DONE = 1'b1
  } lsu_state_t;

  function automatic logic [2:0] access_size(input logic [2:0] funct3);
    logic [2:0] size;
    case (funct3)
      F3_B, F3_BU: size = 3'd1;
      F3_H, F3_HU: size = 3'd2;
      default:     size = 3'd4;
    endcase
    return size;
  endfunction

  function automatic logic illegal_funct3(input logic [2:0] funct3);
    return !(funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
  endfunction

endpackage

// File: rtl/rv_lsu_align.sv
// Combinational lane alignment: byte-strobe mask, shifted store data and the
// extended load result from a {hi, lo} word pair.
module rv_lsu_align #(
  parameter int unsigned XLEN = 32
) (
  input  logic [2:0]        i_funct3,
  input  logic [1:0]        i_off,
  input  logic [XLEN-1:0]   i_wdata,
  input  logic [XLEN-1:0]   i_hi_word,
  input  logic [XLEN-1:0]   i_lo_word,
  output logic [7:0]        o_mask,
  output logic [2*XLEN-1:0] o_wdata_wide,
  output logic [XLEN-1:0]   o_rdata
);
  import rv_pkg::*;

  logic [3:0]        size_mask;
  logic [2*XLEN-1:0] rd_wide;
  logic [XLEN-1:0]   rd_raw;
  logic [5:0]        shamt;

  always_comb begin
    shamt = {1'b0, i_off, 3'b000};
    case (access_size(i_funct3))
      3'd1:    size_mask = 4'b0001;
      3'd2:    size_mask = 4'b0011;
      default: size_mask = 4'b1111;
    endcase
    o_mask       = {4'b0000, size_mask} << i_off;
    o_wdata_wide = {{XLEN{1'b0}}, i_wdata} << shamt;
    // Non-split loads pass the same word as hi and lo, so the shift still works.
    rd_wide      = {i_hi_word, i_lo_word} >> shamt;
    rd_raw       = rd_wide[XLEN-1:0];
    case (i_funct3)
      F3_B:    o_rdata = {{(XLEN-8){rd_raw[7]}}, rd_raw[7:0]};
      F3_H:    o_rdata = {{(XLEN-16){rd_raw[15]}}, rd_raw[15:0]};
      F3_BU:   o_rdata = {{(XLEN-8){1'b0}}, rd_raw[7:0]};
      F3_HU:   o_rdata = {{(XLEN-16){1'b0}}, rd_raw[15:0]};
      default: o_rdata = rd_raw;
    endcase
  end

endmodule

// File: rtl/rv_lsu.sv
// MEM-stage load/store unit: drives the data memory, extends load data and splits
// word-crossing accesses into two back-to-back word accesses with a one-cycle stall.
module rv_lsu #(
  parameter int unsigned XLEN          = 32,
  parameter int unsigned DMEM_ADDR_BIT = 12
) (
  input  logic                     i_lsu_clk,
  input  logic                     i_lsu_rstn,
  input  logic                     i_lsu_valid,
  input  logic                     i_lsu_we,
  input  logic [2:0]               i_lsu_funct3,
  input  logic [XLEN-1:0]          i_lsu_addr,
  input  logic [XLEN-1:0]          i_lsu_wdata,
  input  logic [XLEN-1:0]          i_lsu_dmem_rdata,
  output logic [DMEM_ADDR_BIT-3:0] o_lsu_dmem_addr,
  output logic                     o_lsu_dmem_wen,
  output logic [XLEN/8-1:0]        o_lsu_dmem_wstrb,
  output logic [XLEN-1:0]          o_lsu_dmem_wdata,
  output logic [XLEN-1:0]          o_lsu_rdata,
  output logic                     o_lsu_stall,
  output logic                     o_lsu_done,
  output logic                     o_lsu_fault,
  output logic [15:0]              o_lsu_split_cnt
);
  import rv_pkg::*;

  localparam int unsigned IDX_W = DMEM_ADDR_BIT - 2;

  lsu_state_t        state_q, state_d;
  logic [XLEN-1:0]   lo_buf_q, lo_buf_d;
  logic [15:0]       split_cnt_q, split_cnt_d;

  logic              fault;
  logic              split;
  logic [1:0]        off;
  logic [IDX_W-1:0]  idx;
  logic [7:0]        mask;
  logic [2*XLEN-1:0] wdata_wide;
  logic [XLEN-1:0]   lo_word;
  logic [XLEN-1:0]   ext_rdata;
  logic              unused_addr_bits;

  assign off              = i_lsu_addr[1:0];
  assign idx              = i_lsu_addr[DMEM_ADDR_BIT-1:2];
  assign fault            = i_lsu_valid & illegal_funct3(i_lsu_funct3);
  assign split            = ({1'b0, off} + access_size(i_lsu_funct3)) > 3'd4;
  assign lo_word          = (state_q == FIRST_DONE) ? lo_buf_q : i_lsu_dmem_rdata;
  assign unused_addr_bits = ^i_lsu_addr[XLEN-1:DMEM_ADDR_BIT];
  assign o_lsu_split_cnt  = split_cnt_q;

  rv_lsu_align #(
    .XLEN(XLEN)
  ) u_align (
    .i_funct3     (i_lsu_funct3),
    .i_off        (off),
    .i_wdata      (i_lsu_wdata),
    .i_hi_word    (i_lsu_dmem_rdata),
    .i_lo_word    (lo_word),
    .o_mask       (mask),
    .o_wdata_wide (wdata_wide),
    .o_rdata      (ext_rdata)
  );

  always_comb begin
    state_d          = state_q;
    lo_buf_d         = lo_buf_q;
    split_cnt_d      = split_cnt_q;
    o_lsu_dmem_addr  = idx;
    o_lsu_dmem_wen   = 1'b0;
    o_lsu_dmem_wstrb = mask[3:0];
    o_lsu_dmem_wdata = wdata_wide[XLEN-1:0];
    o_lsu_rdata      = ext_rdata;
    o_lsu_stall      = 1'b0;
    o_lsu_done       = 1'b0;
    o_lsu_fault      = fault;
    case (state_q)
      IDLE: begin
        if (i_lsu_valid && !fault) begin
          o_lsu_dmem_wen = i_lsu_we;
          if (split) begin
            o_lsu_stall = 1'b1;
            lo_buf_d    = i_lsu_dmem_rdata;
            state_d     = FIRST_DONE;
            if (split_cnt_q != '1) split_cnt_d = split_cnt_q + 16'd1;
          end else begin
            o_lsu_done = 1'b1;
          end
        end
      end
      FIRST_DONE: begin
        // Upper half: next word index (wraps), upper strobe/data lanes.
        o_lsu_dmem_addr  = idx + IDX_W'(1);
        o_lsu_dmem_wstrb = mask[7:4];
        o_lsu_dmem_wdata = wdata_wide[2*XLEN-1:XLEN];
        state_d          = IDLE;
        if (i_lsu_valid && !fault) begin
          o_lsu_dmem_wen = i_lsu_we;
          o_lsu_done     = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (!i_lsu_rstn) begin
      o_lsu_dmem_wen   = 1'b0;
      o_lsu_dmem_wstrb = '0;
      o_lsu_rdata      = '0;
      o_lsu_stall      = 1'b0;
      o_lsu_done       = 1'b0;
      o_lsu_fault      = 1'b0;
    end
  end

  always_ff @(posedge i_lsu_clk or negedge i_lsu_rstn) begin
    if (!i_lsu_rstn) begin
      state_q     <= IDLE;
      lo_buf_q    <= '0;
      split_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      lo_buf_q    <= lo_buf_d;
      split_cnt_q <= split_cnt_d;
    end
  end

endmodule

// File: tb/tb_rv_lsu.sv
// Scoreboard bench for rv_lsu: byte-addressed reference memory model, directed
// and randomized accesses, and a monitor that checks every completed access.
module tb_rv_lsu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid = 1'b0;
  logic        we = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] dmem_rdata;
  logic [9:0]  dmem_addr;
  logic        dmem_wen;
  logic [3:0]  dmem_wstrb;
  logic [31:0] dmem_wdata;
  logic [31:0] rdata;
  logic        stall, done, fault;
  logic [15:0] split_cnt;

  always #5 clk = ~clk;

  rv_lsu #(
    .XLEN          (32),
    .DMEM_ADDR_BIT (12)
  ) dut (
    .i_lsu_clk        (clk),
    .i_lsu_rstn       (rst_n),
    .i_lsu_valid      (valid),
    .i_lsu_we         (we),
    .i_lsu_funct3     (funct3),
    .i_lsu_addr       (addr),
    .i_lsu_wdata      (wdata),
    .i_lsu_dmem_rdata (dmem_rdata),
    .o_lsu_dmem_addr  (dmem_addr),
    .o_lsu_dmem_wen   (dmem_wen),
    .o_lsu_dmem_wstrb (dmem_wstrb),
    .o_lsu_dmem_wdata (dmem_wdata),
    .o_lsu_rdata      (rdata),
    .o_lsu_stall      (stall),
    .o_lsu_done       (done),
    .o_lsu_fault      (fault),
    .o_lsu_split_cnt  (split_cnt)
  );

  // Data memory seen by the DUT: combinational read, strobed write.
  logic [31:0] dmem [0:1023];
  assign dmem_rdata = dmem[dmem_addr];
  always @(posedge clk) begin
    if (dmem_wen)
      for (int b = 0; b < 4; b++)
        if (dmem_wstrb[b]) dmem[dmem_addr][8*b +: 8] <= dmem_wdata[8*b +: 8];
  end

  // Reference: flat 4 KiB byte array, addresses wrap modulo 4096.
  logic [7:0] ref_mem [0:4095];
  int model_cnt = 0;
  int n_tests = 0;
  int n_fail = 0;

  typedef struct {
    bit          is_fault;
    bit          is_load;
    bit          is_split;
    logic [31:0] rdata;
  } exp_t;
  exp_t exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", name, act, expv);
    end
  endtask

  function automatic int size_of(input logic [2:0] f3);
    if (f3 == 3'b000 || f3 == 3'b100) return 1;
    if (f3 == 3'b001 || f3 == 3'b101) return 2;
    return 4;
  endfunction

  function automatic bit is_illegal(input logic [2:0] f3);
    return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
  endfunction

  function automatic int baddr(input logic [31:0] a, input int k);
    return (int'(a[11:0]) + k) % 4096;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a);
    logic [31:0] v;
    v = '0;
    for (int k = 0; k < size_of(f3); k++) v[8*k +: 8] = ref_mem[baddr(a, k)];
    case (f3)
      3'b000:  return v[7] ? (v | 32'hFFFF_FF00) : v;
      3'b001:  return v[15] ? (v | 32'hFFFF_0000) : v;
      default: return v;
    endcase
  endfunction

  task automatic model_store(input logic [31:0] a, input logic [31:0] d, input int nbytes);
    for (int k = 0; k < nbytes; k++) ref_mem[baddr(a, k)] = d[8*k +: 8];
  endtask

  function automatic logic [31:0] lane_mask(input logic [3:0] s);
    logic [31:0] m;
    for (int b = 0; b < 4; b++) m[8*b +: 8] = {8{s[b]}};
    return m;
  endfunction

  // Issue one access at posedge+1; returns at posedge+1 after it completes.
  task automatic access(input bit st, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] d);
    exp_t        e;
    bit          ill, spl;
    int          s, off;
    logic [3:0]  strb [2];
    logic [31:0] wd [2];
    logic [9:0]  idx [2];
    ill  = is_illegal(f3);
    s    = size_of(f3);
    off  = int'(a[1:0]);
    spl  = !ill && (off + s > 4);
    strb[0] = '0; strb[1] = '0; wd[0] = '0; wd[1] = '0;
    for (int k = 0; k < s; k++) begin
      int p;
      p = off + k;
      strb[p / 4][p % 4] = 1'b1;
      wd[p / 4][8*(p % 4) +: 8] = d[8*k +: 8];
    end
    idx[0] = a[11:2];
    idx[1] = 10'((int'(a[11:2]) + 1) % 1024);
    e.is_fault = ill;
    e.is_load  = !st;
    e.is_split = spl;
    e.rdata    = (!st && !ill) ? model_load(f3, a) : 32'h0;
    if (st && !ill) model_store(a, d, s);
    if (spl && model_cnt < 16'hFFFF) model_cnt++;
    exp_q.push_back(e);
    valid = 1'b1; we = st; funct3 = f3; addr = a; wdata = d;
    for (int c = 0; c < (spl ? 2 : 1); c++) begin
      #1;
      if (ill) begin
        chk("fault_wen", dmem_wen, 0);
        chk("fault_stall", stall, 0);
      end else begin
        chk("word_index", dmem_addr, idx[c]);
        chk("wen", dmem_wen, st);
        if (st) begin
          chk("wstrb", dmem_wstrb, strb[c]);
          chk("wdata_lanes", dmem_wdata & lane_mask(strb[c]), wd[c]);
        end
      end
      @(posedge clk);
    end
    #1;
    valid = 1'b0;
  endtask

  // Monitor: every done/fault cycle is matched against the oldest expectation.
  initial begin
    exp_t e;
    bit   prev_stall;
    prev_stall = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && (done || fault)) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_completion: got done=%0b fault=%0b expected no access", done, fault);
        end else begin
          e = exp_q.pop_front();
          chk("mon_fault", fault, e.is_fault);
          chk("mon_split_stall", prev_stall, e.is_split);
          chk("mon_wen", dmem_wen, !e.is_load && !e.is_fault);
          if (e.is_load && !e.is_fault) chk("mon_rdata", rdata, e.rdata);
        end
      end
      prev_stall = rst_n && stall;
    end
  end

  initial begin
    logic [31:0] r, a;
    logic [2:0]  f3;
    int          pick;
    logic [2:0]  legal [5];
    legal[0] = 3'b000; legal[1] = 3'b001; legal[2] = 3'b010;
    legal[3] = 3'b100; legal[4] = 3'b101;

    for (int w = 0; w < 1024; w++) begin
      r = $urandom;
      if (w == 0) r = 32'h4433_2211;
      if (w == 1) r = 32'h8877_6655;
      dmem[w] = r;
      for (int b = 0; b < 4; b++) ref_mem[4*w + b] = r[8*b +: 8];
    end

    // Outputs held quiet while reset is asserted, even with a valid store pending.
    valid = 1'b1; we = 1'b1; funct3 = 3'b010; addr = 32'h3; wdata = 32'hDEAD_BEEF;
    #12;
    chk("rst_wen", dmem_wen, 0);
    chk("rst_stall", stall, 0);
    chk("rst_done", done, 0);
    chk("rst_fault", fault, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_wstrb", dmem_wstrb, 0);
    chk("rst_split_cnt", split_cnt, 0);
    valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    access(1'b0, 3'b010, 32'h4, '0);
    access(1'b0, 3'b001, 32'h3, '0);
    chk("split_cnt_after_lh", split_cnt, 1);
    access(1'b0, 3'b010, 32'h2, '0);
    access(1'b0, 3'b000, 32'h7, '0);
    access(1'b0, 3'b100, 32'h7, '0);
    access(1'b0, 3'b011, 32'h8, '0);
    access(1'b1, 3'b011, 32'h8, 32'h1234_5678);
    access(1'b1, 3'b000, 32'h5, 32'h0000_00AB);
    access(1'b1, 3'b010, 32'h3, 32'hDEAD_BEEF);
    access(1'b0, 3'b010, 32'h0, '0);
    access(1'b0, 3'b010, 32'h4, '0);

    // Split store aborted by reset during its second cycle: upper half never lands.
    valid = 1'b1; we = 1'b1; funct3 = 3'b010; addr = 32'h3; wdata = 32'h1122_3344;
    model_store(32'h3, 32'h1122_3344, 1);
    #1;
    chk("abort_c1_stall", stall, 1);
    chk("abort_c1_index", dmem_addr, 0);
    chk("abort_c1_wstrb", dmem_wstrb, 4'b1000);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("abort_rst_wen", dmem_wen, 0);
    chk("abort_rst_done", done, 0);
    chk("abort_rst_split_cnt", split_cnt, 0);
    model_cnt = 0;
    valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    access(1'b0, 3'b010, 32'h4, '0);
    access(1'b0, 3'b010, 32'h0, '0);

    // Split word store at the top word index wraps to index 0.
    access(1'b1, 3'b010, 32'hFFD, 32'hCAFE_F00D);
    access(1'b0, 3'b010, 32'hFFD, '0);
    access(1'b0, 3'b010, 32'h0, '0);
    access(1'b0, 3'b101, 32'hFFF, '0);

    for (int i = 0; i < 400; i++) begin
      pick = $urandom_range(0, 15);
      f3 = (pick < 13) ? legal[pick % 5] : ((pick == 13) ? 3'b011 : ((pick == 14) ? 3'b110 : 3'b111));
      a = $urandom;
      a[11:0] = ($urandom_range(0, 1) == 1) ? 12'($urandom_range(0, 63)) : 12'(4032 + $urandom_range(0, 63));
      access($urandom_range(0, 2) == 0, f3, a, $urandom);
    end

    @(posedge clk); #1;
    chk("queue_drained", exp_q.size(), 0);
    chk("final_split_cnt", split_cnt, model_cnt);
    for (int w = 0; w < 1024; w++)
      chk("final_mem_word", dmem[w],
          {ref_mem[4*w + 3], ref_mem[4*w + 2], ref_mem[4*w + 1], ref_mem[4*w]});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
